// File: rtl/lsfr_pkg.sv
// Shared constants and step function for the 10-bit Fibonacci LFSR.
// Polynomial x^10 + x^7 + 1, maximal length 1023.
package lsfr_pkg;

    localparam int LFSR_W = 10;
    localparam int TAP_HI = 9;
    localparam int TAP_LO = 6;
    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 10'h001;
    localparam int PERIOD = 1023;

    function automatic logic [LFSR_W-1:0] lfsr_step(
        input logic [LFSR_W-1:0] state
    );
        logic w_fb;
        w_fb = state[TAP_HI] ^ state[TAP_LO];
        return {state[LFSR_W-2:0], w_fb};
    endfunction

    // All-zero seed would lock the register, so substitute the default.
    function automatic logic [LFSR_W-1:0] legal_seed(
        input logic [LFSR_W-1:0] seed
    );
        return (seed == '0) ? DEFAULT_SEED : seed;
    endfunction

endpackage

// File: rtl/ten_bit_lsfr.sv
// 10-bit Fibonacci LFSR with seed legalisation and lock-up recovery.
// Output is the state register, zero-extended to OUT_W bits.
module ten_bit_lsfr
    import lsfr_pkg::*;
#(
    parameter logic [11:0] START_NUM = 12'h001,
    parameter int          OUT_W     = 10
) (
    output logic [OUT_W-1:0] lsfr_num,
    input  logic             clk,
    input  logic             reset
);

    if (OUT_W < LFSR_W || OUT_W > 32) begin : g_bad_width
        $fatal(1, "ten_bit_lsfr: OUT_W must be in 10..32");
    end

    localparam logic [LFSR_W-1:0] SEED =
        legal_seed(START_NUM[LFSR_W-1:0]);

    logic [LFSR_W-1:0] r_state;
    logic [LFSR_W-1:0] w_next;

    assign w_next = lfsr_step(r_state);

    // A zero state can only come from upset or force; reseed on it.
    always_ff @(posedge clk) begin
        if (!reset || r_state == '0) begin
            r_state <= SEED;
        end else begin
            r_state <= w_next;
        end
    end

    assign lsfr_num = OUT_W'(r_state);

endmodule

// File: tb/tb_ten_bit_lsfr.sv
// Directed self-checking bench for ten_bit_lsfr.
// Four instances: main seed, zero seed, ignored-high-bits seed, wide output.
module tb_ten_bit_lsfr;

    logic        clk;
    logic        reset;
    logic [9:0]  num;
    logic [9:0]  num_z;
    logic [9:0]  num_c;
    logic [17:0] num_18;

    int checks;
    int errors;

    ten_bit_lsfr #(.START_NUM(12'b010011100011), .OUT_W(10)) dut (
        .lsfr_num(num), .clk(clk), .reset(reset)
    );
    ten_bit_lsfr #(.START_NUM(12'h000), .OUT_W(10)) dut_z (
        .lsfr_num(num_z), .clk(clk), .reset(reset)
    );
    ten_bit_lsfr #(.START_NUM(12'hC00), .OUT_W(10)) dut_c (
        .lsfr_num(num_c), .clk(clk), .reset(reset)
    );
    ten_bit_lsfr #(.START_NUM(12'b010011100011), .OUT_W(18)) dut_18 (
        .lsfr_num(num_18), .clk(clk), .reset(reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] model_step(input logic [9:0] s);
        return {s[8:0], s[9] ^ s[6]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        check("hi18", 32'(num_18[17:10]), 32'h0);
        check("lo18", 32'(num_18[9:0]), 32'(num));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("rst", 32'(num), 32'h0E3);
        @(negedge clk);
        reset = 1'b1;
    endtask

    logic [9:0] exp_v;
    bit         seen [1024];
    int         dups;
    int         zeros;

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;

        // Reset load and seed legalisation on all instances
        tick();
        check("rst_main", 32'(num), 32'h0E3);
        check("rst_zero", 32'(num_z), 32'h001);
        check("rst_c00", 32'(num_c), 32'h001);
        tick();
        check("rst_hold", 32'(num), 32'h0E3);

        // First steps after release
        @(negedge clk);
        reset = 1'b1;
        tick();
        check("step1", 32'(num), 32'h1C7);
        check("step1_z", 32'(num_z), 32'h002);
        check("step1_c", 32'(num_c), 32'h002);
        tick();
        check("step2", 32'(num), 32'h38F);

        // Full period: nonzero, unique, returns to seed at 1023
        do_reset();
        exp_v = 10'h0E3;
        dups  = 0;
        zeros = 0;
        for (int i = 0; i < 1024; i++) seen[i] = 1'b0;
        for (int i = 1; i <= 1023; i++) begin
            tick();
            exp_v = model_step(exp_v);
            check("seq", 32'(num), 32'(exp_v));
            if (num == 10'h000) zeros++;
            if (seen[num]) dups++;
            seen[num] = 1'b1;
        end
        check("period", 32'(num), 32'h0E3);
        check("nonzero", 32'(zeros), 32'd0);
        check("unique", 32'(dups), 32'd0);

        // Lock-up recovery from a forced zero state
        tick();
        @(negedge clk);
        force dut.r_state = 10'h000;
        force dut_18.r_state = 10'h000;
        #1;
        release dut.r_state;
        release dut_18.r_state;
        #1;
        check("forced0", 32'(num), 32'h000);
        tick();
        check("lockup", 32'(num), 32'h0E3);
        tick();
        check("lockup+1", 32'(num), 32'h1C7);

        // Mid-sequence reset restarts cleanly
        repeat (100) tick();
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("mid_rst", 32'(num), 32'h0E3);
        @(negedge clk);
        reset = 1'b1;
        tick();
        check("mid_s1", 32'(num), 32'h1C7);
        tick();
        check("mid_s2", 32'(num), 32'h38F);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
